// File: rtl/states_pkg.sv
// Shared state encodings and report constants for the level report transmitter.
package states_pkg;

    typedef enum logic [1:0] {ZERO, LOW, HIGH, MAX} HighLow;

    typedef enum logic [2:0] {INIT, DATA_RX, DATA_TX, STOPBIT, RESET} UART;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam logic [3:0] REPORT_TAG = 4'hA;

    function automatic logic [7:0] report_byte(input HighLow code);
        return {REPORT_TAG, 2'b00, code};
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: pulses bit_done on the last cycle of every CLKS_PER_BIT-cycle bit.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Held at the reload value while disabled, so every rise of en starts a full bit.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = en && (cnt_q == '0);

endmodule

// File: rtl/level_report_tx.sv
// Debounces the 2-bit level code and sends one 8N1 report byte per qualified change,
// with a single newest-wins pending slot while a frame is in flight.
module level_report_tx
    import states_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 16,
    parameter int STABLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state_in,
    input  logic       clr_overrun,
    output logic       tx,
    output logic       busy,
    output logic [7:0] sent_count,
    output logic       overrun
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

    HighLow     state_in_hl;
    HighLow     prev_q, prev_d;
    HighLow     last_q, last_d;
    logic [SW-1:0] stab_q, stab_d;
    logic       qualify;

    tx_state_t  state_q, state_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [2:0] nxt_idx;
    logic [7:0] payload_q, payload_d;
    logic       pend_valid_q, pend_valid_d;
    HighLow     pend_code_q, pend_code_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic [7:0] sent_q, sent_d;
    logic       overrun_q, overrun_d;

    logic       bit_done;
    logic       frame_end;
    logic       launch;
    logic       qual_direct;
    HighLow     launch_code;

    assign state_in_hl = HighLow'(state_in);

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != TX_IDLE),
        .bit_done(bit_done)
    );

    // Qualify on the cycle the counter reaches its cap, so a level held STABLE_CYCLES cycles reports.
    always_comb begin
        prev_d = state_in_hl;
        stab_d = stab_q;
        if (state_in_hl != prev_q) begin
            stab_d = '0;
        end else if (stab_q != STAB_MAX) begin
            stab_d = stab_q + SW'(1);
        end
        qualify = (stab_d == STAB_MAX) && (state_in_hl != last_q);
        last_d  = qualify ? state_in_hl : last_q;
    end

    always_comb begin
        frame_end   = (state_q == TX_STOP) && bit_done;
        launch      = ((state_q == TX_IDLE) || frame_end) && (qualify || pend_valid_q);
        qual_direct = launch && qualify && !pend_valid_q;
        launch_code = pend_valid_q ? pend_code_q : state_in_hl;
        nxt_idx     = bit_idx_q + 3'd1;

        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        payload_d    = payload_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        tx_d         = tx_q;
        busy_d       = busy_q;
        sent_d       = sent_q;
        overrun_d    = overrun_q;

        if (clr_overrun) begin
            overrun_d = 1'b0;
        end

        // A launch that consumes the slot frees it for a same-cycle qualify without overrun.
        if (qualify && !qual_direct) begin
            pend_valid_d = 1'b1;
            pend_code_d  = state_in_hl;
            if (pend_valid_q && !launch) begin
                overrun_d = 1'b1;
            end
        end else if (launch) begin
            pend_valid_d = 1'b0;
        end

        case (state_q)
            TX_IDLE: begin
                if (launch) begin
                    state_d   = TX_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    payload_d = report_byte(launch_code);
                end
            end
            TX_START: begin
                if (bit_done) begin
                    state_d   = TX_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = payload_q[0];
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = nxt_idx;
                        tx_d      = payload_q[nxt_idx];
                    end
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    sent_d = sent_q + 8'd1;
                    if (launch) begin
                        state_d   = TX_START;
                        tx_d      = 1'b0;
                        payload_d = report_byte(launch_code);
                    end else begin
                        state_d = TX_IDLE;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q       <= ZERO;
            last_q       <= ZERO;
            stab_q       <= '0;
            state_q      <= TX_IDLE;
            bit_idx_q    <= 3'd0;
            payload_q    <= 8'd0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= ZERO;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            sent_q       <= 8'd0;
            overrun_q    <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            last_q       <= last_d;
            stab_q       <= stab_d;
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            payload_q    <= payload_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            sent_q       <= sent_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign sent_count = sent_q;
    assign overrun    = overrun_q;

endmodule
